instr_encoder: RTL and testbench
================================

# instr_encoder

Assembles MIPS31 instructions for instruction memory. It accepts a one-hot operation select plus operand fields over a valid/ready handshake and encodes them into 32-bit MIPS32 words. Words are buffered in a small FIFO and written sequentially into IMEM starting at a base address. It sits between the test/boot loader and IMEM, and is the exact inverse of the CPU's instruction decoder: decoding an encoded word returns the same one-hot select.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; must be a power of 2, ≥2.
- `BASE_ADDR`, 32'h0000_0000: first IMEM byte address after reset or restart.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `restart`  in  1  sync pulse: discard FIFO contents, reload address to `BASE_ADDR`.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  the block can accept a request this cycle.
- `in_choose`  in  32  one-hot operation select, same bit map as the decoder.
- `in_rs`, `in_rt`, `in_rd`, `in_shamt`  in  5 each  register and shift fields.
- `in_imm`  in  16  I-type immediate.
- `in_target`  in  26  J-type target.
- `imem_ready`  in  1  IMEM accepts a write this cycle.
- `imem_we`  out  1  write strobe.
- `imem_addr`  out  32  byte address.
- `imem_wdata`  out  32  encoded word.
- `err`  out  1  one-cycle pulse: illegal request was rejected.
- `err_cnt`  out  8  count of rejected requests; saturates at 255.
- `busy`  out  1  FIFO is non-empty.

## Operation
- `in_choose` bit map: 0 add, 1 addu, 2 sub, 3 subu, 4 and, 5 or, 6 xor, 7 nor, 8 slt, 9 sltu, 10 sll, 11 srl, 12 sra, 13 sllv, 14 srlv, 15 srav, 16 jr, 17 addi, 18 addiu, 19 andi, 20 ori, 21 xori, 22 lw, 23 sw, 24 beq, 25 bne, 26 slti, 27 sltiu, 28 lui, 29 j, 30 jal. Bit 31 is reserved. All opcode and funct values are standard MIPS32.
- R-type word: `{6'b0, rs, rt, rd, shamt, funct}`.
  - sll/srl/sra: rs field forced to 0.
  - All other R-type ops: shamt field forced to 0.
  - jr: rt, rd and shamt forced to 0.
- I-type word: `{op, rs, rt, imm}`. For lui, rs is forced to 0.
- J-type word: `{op, target}`.
- A request is legal when exactly one of bits 30:0 is set and bit 31 is clear. Legal requests are pushed into the FIFO. Illegal requests are consumed (the handshake completes), not pushed, and raise `err`/`err_cnt`.
- Encoding is combinational at the input; the FIFO stores encoded words.
- Drain: `imem_we` equals `busy`, and `imem_wdata` is the FIFO head. On `imem_we & imem_ready` the entry pops and `imem_addr` increments by 4. The address wraps modulo 2^32.

## Timing
- Reset values: `in_ready`=1, `imem_we`=0, `imem_addr`=`BASE_ADDR`, `imem_wdata`=0, `err`=0, `err_cnt`=0, `busy`=0. FIFO is empty.
- `in_ready` = FIFO not full. It depends only on registered state, never on `in_valid`.
- Handshake at an edge with `in_valid & in_ready`. A legal word pushed at edge k is presented with `imem_we`=1 from cycle k+1, giving minimum latency 1.
- Throughput is 1 word per cycle with simultaneous push and pop.
- When full, `in_ready`=0 even if a pop occurs that cycle; there is no push-through.
- `imem_we`/`imem_addr`/`imem_wdata` are held stable while `imem_ready`=0.
- `err` asserts in cycle k+1 after the rejecting edge k.
- `restart` has priority over push and pop in the same cycle. Next cycle: FIFO empty, `imem_addr`=`BASE_ADDR`. `err_cnt` is preserved.
- `rst_n` asserted mid-drain aborts immediately; any pending words are lost.

## Structure
- Shared package `mips31_pkg`:
  - one-hot bit index constants;
  - opcode and funct constants;
  - an instruction-format enum (R/I/J).
  The decoder will later migrate to the same package.
- One sub-module: `instr_fifo`, a parameterized `DEPTH`×32 synchronous FIFO with async active-low reset, exposing full/empty/push/pop. The encode logic and address counter stay in the top level.

## Test plan
- add rs=1, rt=2, rd=3, shamt=7 -> first write: word 0x00221820 at addr 0x0.
- Stream sll rt=2, rd=4, shamt=3, then lui rt=5, imm=0x1234, then jal target=0x0000010, with `imem_ready`=1 -> words 0x000220C0, 0x3C051234, 0x0C000010 at addrs 0x0, 0x4, 0x8 on consecutive cycles.
- in_choose=0x3 (two bits set), then 0x0, then 0x8000_0000 -> three `err` pulses, `err_cnt`=3, nothing written.
- `imem_ready`=0, push DEPTH words -> `in_ready`=0 after the DEPTH-th accept and outputs stay stable. Release -> DEPTH writes in order.
- `restart` in the same cycle as a valid push and a pending pop -> word dropped, next legal write lands at `BASE_ADDR`.
- Round trip: all 31 ops with random fields -> reference decoder(`imem_wdata`) == `in_choose`. Also check the forced-zero fields.

Source files
------------

// File: rtl/mips31_pkg.sv
// Shared MIPS31 definitions: one-hot select bit positions, opcode/funct
// values and the instruction format classification used by the encoder
// (and, later, by the decoder).
package mips31_pkg;

  // Number of real operations in the one-hot select (bit 31 is reserved)
  localparam int unsigned NUM_OPS = 31;

  // One-hot bit index of each operation in in_choose
  localparam logic [4:0] IDX_ADD   = 5'd0;
  localparam logic [4:0] IDX_ADDU  = 5'd1;
  localparam logic [4:0] IDX_SUB   = 5'd2;
  localparam logic [4:0] IDX_SUBU  = 5'd3;
  localparam logic [4:0] IDX_AND   = 5'd4;
  localparam logic [4:0] IDX_OR    = 5'd5;
  localparam logic [4:0] IDX_XOR   = 5'd6;
  localparam logic [4:0] IDX_NOR   = 5'd7;
  localparam logic [4:0] IDX_SLT   = 5'd8;
  localparam logic [4:0] IDX_SLTU  = 5'd9;
  localparam logic [4:0] IDX_SLL   = 5'd10;
  localparam logic [4:0] IDX_SRL   = 5'd11;
  localparam logic [4:0] IDX_SRA   = 5'd12;
  localparam logic [4:0] IDX_SLLV  = 5'd13;
  localparam logic [4:0] IDX_SRLV  = 5'd14;
  localparam logic [4:0] IDX_SRAV  = 5'd15;
  localparam logic [4:0] IDX_JR    = 5'd16;
  localparam logic [4:0] IDX_ADDI  = 5'd17;
  localparam logic [4:0] IDX_ADDIU = 5'd18;
  localparam logic [4:0] IDX_ANDI  = 5'd19;
  localparam logic [4:0] IDX_ORI   = 5'd20;
  localparam logic [4:0] IDX_XORI  = 5'd21;
  localparam logic [4:0] IDX_LW    = 5'd22;
  localparam logic [4:0] IDX_SW    = 5'd23;
  localparam logic [4:0] IDX_BEQ   = 5'd24;
  localparam logic [4:0] IDX_BNE   = 5'd25;
  localparam logic [4:0] IDX_SLTI  = 5'd26;
  localparam logic [4:0] IDX_SLTIU = 5'd27;
  localparam logic [4:0] IDX_LUI   = 5'd28;
  localparam logic [4:0] IDX_J     = 5'd29;
  localparam logic [4:0] IDX_JAL   = 5'd30;

  // Primary opcodes
  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] OPC_J       = 6'h02;
  localparam logic [5:0] OPC_JAL     = 6'h03;
  localparam logic [5:0] OPC_BEQ     = 6'h04;
  localparam logic [5:0] OPC_BNE     = 6'h05;
  localparam logic [5:0] OPC_ADDI    = 6'h08;
  localparam logic [5:0] OPC_ADDIU   = 6'h09;
  localparam logic [5:0] OPC_SLTI    = 6'h0A;
  localparam logic [5:0] OPC_SLTIU   = 6'h0B;
  localparam logic [5:0] OPC_ANDI    = 6'h0C;
  localparam logic [5:0] OPC_ORI     = 6'h0D;
  localparam logic [5:0] OPC_XORI    = 6'h0E;
  localparam logic [5:0] OPC_LUI     = 6'h0F;
  localparam logic [5:0] OPC_LW      = 6'h23;
  localparam logic [5:0] OPC_SW      = 6'h2B;

  // SPECIAL funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {
    FMT_R = 2'd0,
    FMT_I = 2'd1,
    FMT_J = 2'd2
  } instr_fmt_e;

  // Format of an operation given its one-hot bit index
  function automatic instr_fmt_e fmt_of(input logic [4:0] idx);
    if (idx <= IDX_JR) begin
      return FMT_R;
    end else if (idx <= IDX_LUI) begin
      return FMT_I;
    end
    return FMT_J;
  endfunction

  // funct field for SPECIAL operations (0 for everything else)
  function automatic logic [5:0] funct_of(input logic [4:0] idx);
    case (idx)
      IDX_ADD:  return FN_ADD;
      IDX_ADDU: return FN_ADDU;
      IDX_SUB:  return FN_SUB;
      IDX_SUBU: return FN_SUBU;
      IDX_AND:  return FN_AND;
      IDX_OR:   return FN_OR;
      IDX_XOR:  return FN_XOR;
      IDX_NOR:  return FN_NOR;
      IDX_SLT:  return FN_SLT;
      IDX_SLTU: return FN_SLTU;
      IDX_SLL:  return FN_SLL;
      IDX_SRL:  return FN_SRL;
      IDX_SRA:  return FN_SRA;
      IDX_SLLV: return FN_SLLV;
      IDX_SRLV: return FN_SRLV;
      IDX_SRAV: return FN_SRAV;
      IDX_JR:   return FN_JR;
      default:  return 6'h00;
    endcase
  endfunction

  // Primary opcode for an operation (SPECIAL for all R-type)
  function automatic logic [5:0] opcode_of(input logic [4:0] idx);
    case (idx)
      IDX_ADDI:  return OPC_ADDI;
      IDX_ADDIU: return OPC_ADDIU;
      IDX_ANDI:  return OPC_ANDI;
      IDX_ORI:   return OPC_ORI;
      IDX_XORI:  return OPC_XORI;
      IDX_LW:    return OPC_LW;
      IDX_SW:    return OPC_SW;
      IDX_BEQ:   return OPC_BEQ;
      IDX_BNE:   return OPC_BNE;
      IDX_SLTI:  return OPC_SLTI;
      IDX_SLTIU: return OPC_SLTIU;
      IDX_LUI:   return OPC_LUI;
      IDX_J:     return OPC_J;
      IDX_JAL:   return OPC_JAL;
      default:   return OPC_SPECIAL;
    endcase
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// DEPTH x WIDTH synchronous FIFO with head-of-queue visible combinationally.
// Pointers carry one extra wrap bit to tell full from empty.
module instr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values; flush wins over push and pop
  always_comb begin
    do_push  = push & ~full & ~flush;
    do_pop   = pop & ~empty & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
    end
  end

  // Pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset since empty masks them
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes one-hot MIPS31 operation requests into 32-bit instruction words,
// buffers them and writes them sequentially into IMEM from BASE_ADDR.
module instr_encoder
  import mips31_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_choose,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  input  logic        imem_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        err,
  output logic [7:0]  err_cnt,
  output logic        busy
);

  logic [4:0]  op_idx;
  logic        legal;
  instr_fmt_e  fmt;
  logic [4:0]  rs_f, rt_f, rd_f, sh_f;
  logic [31:0] enc_word;

  logic        accept, push, reject, pop;
  logic [31:0] addr_q, addr_d;
  logic        err_q, err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic [31:0] fifo_head;
  logic        fifo_full, fifo_empty;

  // Legal means exactly one of bits 30:0 set and the reserved bit clear
  assign legal = ~in_choose[31] && (in_choose[30:0] != '0) &&
                 ((in_choose[30:0] & (in_choose[30:0] - 31'd1)) == '0);

  // Convert the one-hot select to a bit index (only meaningful when legal)
  always_comb begin
    op_idx = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (in_choose[i]) op_idx = 5'(i);
    end
  end

  // Build the instruction word, zeroing fields the format does not use
  always_comb begin
    rs_f     = in_rs;
    rt_f     = in_rt;
    rd_f     = in_rd;
    sh_f     = in_shamt;
    enc_word = '0;
    fmt      = fmt_of(op_idx);
    case (fmt)
      FMT_R: begin
        // Only the immediate shifts carry shamt; they have no rs operand
        if (op_idx == IDX_SLL || op_idx == IDX_SRL || op_idx == IDX_SRA) begin
          rs_f = '0;
        end else begin
          sh_f = '0;
        end
        if (op_idx == IDX_JR) begin
          rt_f = '0;
          rd_f = '0;
        end
        enc_word = {OPC_SPECIAL, rs_f, rt_f, rd_f, sh_f, funct_of(op_idx)};
      end
      FMT_I: begin
        if (op_idx == IDX_LUI) rs_f = '0;
        enc_word = {opcode_of(op_idx), rs_f, rt_f, in_imm};
      end
      FMT_J: begin
        enc_word = {opcode_of(op_idx), in_target};
      end
      default: enc_word = '0;
    endcase
  end

  // Handshake, drain and error bookkeeping
  always_comb begin
    accept    = in_valid & in_ready;
    push      = accept & legal & ~restart;
    reject    = accept & ~legal;
    pop       = imem_we & imem_ready;
    addr_d    = addr_q;
    err_d     = reject;
    err_cnt_d = err_cnt_q;
    if (restart) begin
      addr_d = BASE_ADDR;
    end else if (pop) begin
      addr_d = addr_q + 32'd4;
    end
    if (reject && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Address and error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= BASE_ADDR;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      addr_q    <= addr_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (restart),
    .push      (push),
    .push_data (enc_word),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign in_ready   = ~fifo_full;
  assign busy       = ~fifo_empty;
  assign imem_we    = ~fifo_empty;
  assign imem_wdata = fifo_empty ? 32'h0 : fifo_head;
  assign imem_addr  = addr_q;
  assign err        = err_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, fill/stall,
// restart, saturation, async reset and a randomized scoreboard phase.
module tb_instr_encoder;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        restart = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_choose = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic        imem_ready = 1'b0;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        err;
  logic [7:0]  err_cnt;
  logic        busy;

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .restart    (restart),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_choose  (in_choose),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_shamt   (in_shamt),
    .in_imm     (in_imm),
    .in_target  (in_target),
    .imem_ready (imem_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .err        (err),
    .err_cnt    (err_cnt),
    .busy       (busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  // ---------------- reference model (from the ISA tables) ----------------
  localparam logic [5:0] FN [0:16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                       6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02,
                                       6'h03, 6'h04, 6'h06, 6'h07, 6'h08};
  localparam logic [5:0] OP [17:30] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h23,
                                        6'h2B, 6'h04, 6'h05, 6'h0A, 6'h0B, 6'h0F,
                                        6'h02, 6'h03};

  function automatic logic [31:0] model_encode(input int idx, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
      input logic [15:0] imm, input logic [25:0] tgt);
    logic [4:0] r_s, r_t, r_d, s_h;
    r_s = rs; r_t = rt; r_d = rd; s_h = sh;
    if (idx <= 16) begin
      if (idx >= 10 && idx <= 12) r_s = 5'd0;
      else s_h = 5'd0;
      if (idx == 16) begin r_t = 5'd0; r_d = 5'd0; end
      return {6'd0, r_s, r_t, r_d, s_h, FN[idx]};
    end else if (idx <= 28) begin
      if (idx == 28) r_s = 5'd0;
      return {OP[idx], r_s, r_t, imm};
    end
    return {OP[idx], tgt};
  endfunction

  function automatic logic [31:0] ref_decode(input logic [31:0] w);
    logic [31:0] r;
    r = '0;
    if (w[31:26] == 6'd0) begin
      for (int i = 0; i <= 16; i++) if (w[5:0] == FN[i]) r[i] = 1'b1;
    end else begin
      for (int i = 17; i <= 30; i++) if (w[31:26] == OP[i]) r[i] = 1'b1;
    end
    return r;
  endfunction

  // 1 when every field the op ignores is zero in the word
  function automatic logic zero_fields_ok(input logic [31:0] w, input int idx);
    if (idx >= 10 && idx <= 12) return (w[25:21] == 5'd0);
    if (idx == 16) return (w[20:6] == 15'd0);
    if (idx < 16) return (w[10:6] == 5'd0);
    if (idx == 28) return (w[25:21] == 5'd0);
    return 1'b1;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] choose;
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] word;
    logic        bad;
  } vec_t;

  vec_t vecs [13];

  task automatic drive_fields(input logic [31:0] ch, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm, input logic [25:0] tgt);
    in_choose = ch; in_rs = rs; in_rt = rt; in_rd = rd;
    in_shamt = sh; in_imm = imm; in_target = tgt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard for the random phase ----------------
  typedef struct {
    logic [31:0] word;
    logic [31:0] choose;
  } exp_t;

  exp_t        sb [$];
  exp_t        mon_e;
  logic        mon_en = 1'b0;
  logic [31:0] exp_addr;

  // Every IMEM write that completes must match the oldest accepted request
  always @(negedge clk) begin
    if (mon_en && imem_we && imem_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_write", imem_wdata, 32'hDEAD_BEEF);
      end else begin
        mon_e = sb.pop_front();
        chk("rnd_wdata", imem_wdata, mon_e.word);
        chk("rnd_addr", imem_addr, exp_addr);
        chk("rnd_decode", ref_decode(imem_wdata), mon_e.choose);
        chk("rnd_zero_fields", 32'(zero_fields_ok(imem_wdata, $clog2(mon_e.choose))), 32'd1);
        exp_addr = exp_addr + 32'd4;
      end
    end
  end

  logic [31:0] fill_words [DEPTH];
  logic [31:0] w_tmp;
  int          idx;
  int          exp_err;
  int          budget;
  logic        bad;

  initial begin
    vecs[0]  = '{32'h0000_0001, 5'd1,  5'd2, 5'd3, 5'd7,  16'h0000, 26'h0,       32'h0022_1820, 1'b0}; // add
    vecs[1]  = '{32'h0000_0400, 5'd5,  5'd2, 5'd4, 5'd3,  16'h0000, 26'h0,       32'h0002_20C0, 1'b0}; // sll
    vecs[2]  = '{32'h1000_0000, 5'd7,  5'd5, 5'd0, 5'd0,  16'h1234, 26'h0,       32'h3C05_1234, 1'b0}; // lui
    vecs[3]  = '{32'h4000_0000, 5'd0,  5'd0, 5'd0, 5'd0,  16'h0000, 26'h10,      32'h0C00_0010, 1'b0}; // jal
    vecs[4]  = '{32'h0000_0003, 5'd1,  5'd1, 5'd1, 5'd1,  16'h0001, 26'h1,       32'h0,         1'b1};
    vecs[5]  = '{32'h0000_0000, 5'd1,  5'd1, 5'd1, 5'd1,  16'h0001, 26'h1,       32'h0,         1'b1};
    vecs[6]  = '{32'h8000_0000, 5'd1,  5'd1, 5'd1, 5'd1,  16'h0001, 26'h1,       32'h0,         1'b1};
    vecs[7]  = '{32'h0001_0000, 5'd31, 5'd5, 5'd6, 5'd7,  16'h0000, 26'h0,       32'h03E0_0008, 1'b0}; // jr
    vecs[8]  = '{32'h0000_0800, 5'd9,  5'd3, 5'd2, 5'd31, 16'h0000, 26'h0,       32'h0003_17C2, 1'b0}; // srl
    vecs[9]  = '{32'h0080_0000, 5'd29, 5'd8, 5'd0, 5'd0,  16'hFFFC, 26'h0,       32'hAFA8_FFFC, 1'b0}; // sw
    vecs[10] = '{32'h0100_0000, 5'd1,  5'd2, 5'd0, 5'd0,  16'h0003, 26'h0,       32'h1022_0003, 1'b0}; // beq
    vecs[11] = '{32'h2000_0000, 5'd0,  5'd0, 5'd0, 5'd0,  16'h0000, 26'h3FFFFFF, 32'h0BFF_FFFF, 1'b0}; // j
    vecs[12] = '{32'h0000_0080, 5'd1,  5'd2, 5'd3, 5'd5,  16'h0000, 26'h0,       32'h0022_1827, 1'b0}; // nor

    // ---- reset state ----
    step();
    step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_imem_addr", imem_addr, BASE);
    chk("rst_imem_wdata", imem_wdata, 0);
    chk("rst_err", err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();

    // ---- vector table, streamed one request per cycle ----
    exp_addr   = BASE;
    imem_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive_fields(vecs[i].choose, vecs[i].rs, vecs[i].rt, vecs[i].rd,
                   vecs[i].sh, vecs[i].imm, vecs[i].tgt);
      in_valid = 1'b1;
      step();
      chk("vec_in_ready", in_ready, 1);
      if (vecs[i].bad) begin
        chk("vec_err_pulse", err, 1);
        chk("vec_bad_no_write", imem_we, 0);
      end else begin
        chk("vec_err_low", err, 0);
        chk("vec_we", imem_we, 1);
        chk("vec_wdata", imem_wdata, vecs[i].word);
        chk("vec_addr", imem_addr, exp_addr);
        exp_addr = exp_addr + 32'd4;
      end
      if (i == 6) chk("vec_err_cnt3", err_cnt, 3);
    end
    in_valid = 1'b0;
    step();
    chk("vec_drained", busy, 0);
    chk("vec_err_after", err, 0);

    // ---- fill while IMEM stalls, then release ----
    imem_ready = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      idx = $urandom_range(0, 30);
      drive_fields(32'd1 << idx, 5'($urandom), 5'($urandom), 5'($urandom),
                   5'($urandom), 16'($urandom), 26'($urandom));
      fill_words[i] = model_encode(idx, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target);
      in_valid = 1'b1;
      step();
      chk("fill_in_ready", in_ready, (i < int'(DEPTH) - 1) ? 1 : 0);
      chk("fill_hold_wdata", imem_wdata, fill_words[0]);
      chk("fill_hold_addr", imem_addr, exp_addr);
      chk("fill_hold_we", imem_we, 1);
    end
    // extra offer while full must not be taken
    drive_fields(32'h0000_0001, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0);
    step();
    step();
    chk("full_in_ready", in_ready, 0);
    chk("full_hold_wdata", imem_wdata, fill_words[0]);
    in_valid = 1'b0;
    imem_ready = 1'b1;
    chk("no_push_through", in_ready, 0);
    for (int i = 0; i < int'(DEPTH); i++) begin
      chk("drain_we", imem_we, 1);
      chk("drain_wdata", imem_wdata, fill_words[i]);
      chk("drain_addr", imem_addr, exp_addr);
      exp_addr = exp_addr + 32'd4;
      step();
    end
    chk("drain_empty", busy, 0);

    // ---- restart with simultaneous push and pending pop ----
    imem_ready = 1'b0;
    drive_fields(32'h0000_0001, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    in_valid = 1'b1;
    step();
    chk("rs_pending", busy, 1);
    imem_ready = 1'b1;
    restart = 1'b1;
    drive_fields(32'h0000_0020, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0);
    step();
    restart = 1'b0;
    in_valid = 1'b0;
    chk("rs_busy", busy, 0);
    chk("rs_addr", imem_addr, BASE);
    chk("rs_err_cnt_kept", err_cnt, 3);
    exp_addr = BASE;
    drive_fields(32'h0000_0004, 5'd7, 5'd8, 5'd9, 5'd0, 16'h0, 26'h0);
    w_tmp = model_encode(2, 5'd7, 5'd8, 5'd9, 5'd0, 16'h0, 26'h0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("rs_first_wdata", imem_wdata, w_tmp);
    chk("rs_first_addr", imem_addr, BASE);
    step();
    exp_addr = BASE + 32'd4;

    // ---- randomized stream against the scoreboard ----
    exp_err = 0;
    mon_en  = 1'b1;
    for (int n = 0; n < 400; n++) begin
      imem_ready = ($urandom_range(0, 3) != 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      idx = $urandom_range(0, 30);
      drive_fields(32'd1 << idx, 5'($urandom), 5'($urandom), 5'($urandom),
                   5'($urandom), 16'($urandom), 26'($urandom));
      bad = ($urandom_range(0, 15) == 0);
      if (bad) begin
        case ($urandom_range(0, 2))
          0: in_choose = 32'h0;
          1: in_choose = in_choose | (32'd1 << ((idx + 1) % 31));
          default: in_choose = in_choose | 32'h8000_0000;
        endcase
      end
      if (in_valid && in_ready) begin
        if (bad) exp_err++;
        else sb.push_back('{model_encode(idx, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target),
                            in_choose});
      end
      step();
    end
    in_valid   = 1'b0;
    imem_ready = 1'b1;
    budget = 0;
    while ((sb.size() != 0 || busy) && budget < 50) begin
      step();
      budget++;
    end
    chk("rnd_drain_left", sb.size(), 0);
    chk("rnd_busy", busy, 0);
    mon_en = 1'b0;
    chk("rnd_err_cnt", err_cnt, 32'(3 + exp_err));

    // ---- error counter saturation ----
    in_choose = 32'h0;
    in_valid  = 1'b1;
    for (int n = 0; n < 260; n++) step();
    chk("sat_err_cnt", err_cnt, 255);
    chk("sat_err_pulse", err, 1);
    step();
    chk("sat_err_cnt_hold", err_cnt, 255);
    in_valid = 1'b0;
    step();
    chk("sat_no_write", busy, 0);

    // ---- async reset in the middle of a drain ----
    imem_ready = 1'b0;
    drive_fields(32'h0000_0002, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    chk("ar_pending", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_we", imem_we, 0);
    chk("ar_addr", imem_addr, BASE);
    chk("ar_err_cnt", err_cnt, 0);
    chk("ar_in_ready", in_ready, 1);
    step();
    rst_n = 1'b1;
    imem_ready = 1'b1;
    step();
    chk("ar_after_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
